axis_pattern_gen: RTL and testbench
===================================

Name: axis_pattern_gen

Overview:
- Parametrised AXI4-Stream video test-pattern source; successor to the native-timing counter generator.
- Produces active video directly on AXI-Stream with proper backpressure, so no native-to-AXIS bridge is needed.
- Supports N pixels per clock, four selectable patterns, and programmable inter-line and inter-frame idle gaps.
- Sits at the input of the VDMA write path as stimulus for simulation and board bring-up.

Parameters:
DSIZE, 24, bits per pixel; must be a multiple of 3 (CW = DSIZE/3 bits per colour channel)
PPC, 1, pixels per beat (1, 2 or 4); H_ACTIVE must be divisible by PPC
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
LINE_GAP, 0, idle cycles after each line's last beat (tvalid low)
FRAME_GAP, 16, idle cycles after each frame's last beat, replacing LINE_GAP on that line
CHK_LOG2, 4, checker square size = 2^CHK_LOG2 pixels

Ports:
clock  in  1  single clock for all logic
rst  in  1  synchronous reset, active-high
enable  in  1  run request; sampled at frame boundaries only
mode  in  2  pattern: 0 counter, 1 colour bars, 2 checker, 3 solid
solid_color  in  DSIZE  pixel value used in mode 3
axis_tdata  out  DSIZE*PPC  pixels; pixel k of the beat occupies bits [k*DSIZE +: DSIZE], leftmost pixel at k=0
axis_tvalid  out  1  beat valid
axis_tready  in  1  sink ready
axis_tuser  out  1  start of frame; asserted on first beat of frame only
axis_tlast  out  1  end of line; asserted on last beat of each line
busy  out  1  high whenever state is not IDLE
frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0; state IDLE; x=0, y=0; latched mode=0.
- States: IDLE, ACTIVE, LGAP, FGAP.
- IDLE:
  - enable=1 -> ACTIVE on the next cycle.
  - mode and solid_color are latched on that transition and held for the whole frame.
  - First beat carries tuser=1.
  - Latency from enable high to tvalid high: 1 cycle.
- ACTIVE:
  - tvalid=1 continuously.
  - A beat completes on tvalid&&tready; x advances by PPC.
  - While tready=0, tdata, tuser and tlast hold stable.
  - tvalid is registered; there is no combinational path from tready to any output.
- End of line: on the beat with x=H_ACTIVE-PPC, tlast=1.
  - If y<V_ACTIVE-1: y++, x=0, go to LGAP (or stay in ACTIVE if LINE_GAP=0).
  - If y=V_ACTIVE-1: frame_cnt++, y=0, x=0, go to FGAP.
- LGAP: tvalid=0 for exactly LINE_GAP cycles, then ACTIVE.
- FGAP:
  - tvalid=0 for exactly FRAME_GAP cycles (minimum 1 cycle even if FRAME_GAP=0).
  - Then, if enable=1: relatch mode and solid_color, go to ACTIVE with tuser on the first beat.
  - Otherwise go to IDLE.
- enable dropped mid-frame: the frame completes in full (all lines, tlast on each). No truncated frame is ever emitted.
- Pixel value for pixel at column px = x+k, row y:
  - mode 0: px truncated to DSIZE bits, restarting at 0 every line.
  - mode 1: bar = floor(px*8/H_ACTIVE), computed from constant boundaries.
    - Colours for bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    - Channel order within a pixel is {R,G,B}, with R in the MSBs; each channel is all-ones or 0.
  - mode 2: ((px>>CHK_LOG2) ^ (y>>CHK_LOG2)) & 1 ? all-ones : 0.
  - mode 3: latched solid_color.
- tdata is a registered function of the current x, y and the latched mode. It is updated when a beat completes or on entry to ACTIVE.
- rst asserted at any time, including mid-beat with tvalid high: next cycle all outputs are 0 and state is IDLE. No handshake completion is required.
- frame_cnt increments in the same cycle as the final tlast handshake.

Test Plan:
1. Setup: DSIZE=24, PPC=1, H=8, V=4, LINE_GAP=2, FRAME_GAP=3; mode 0, tready=1, enable pulsed high.
   - Expect 32 beats; tdata 0..7 on each line; tuser on beat 0 only; tlast on beats 7, 15, 23, 31.
   - Expect 2 idle cycles between lines, then IDLE with frame_cnt=1.
2. Same setup with tready toggled 1010 pseudo-randomly.
   - Expect identical beat sequence; no tdata, tuser or tlast change while tvalid&&!tready.
3. PPC=4, H=16, mode 1.
   - Beat 0 tdata = {white,white,yellow,yellow} in pixels 0..3, i.e. 0xFFFF00_FFFF00_FFFFFF_FFFFFF from MSB.
   - Last beat = {blue,blue,black,black}.
4. Mode 2, CHK_LOG2=1, H=8, V=4.
   - Row 0 pixels = 0,0,F,F,0,0,F,F (F = all-ones); row 2 inverted.
5. enable held high across frames, mode changed 0->3 mid-frame.
   - Current frame finishes in mode 0; next frame, after exactly FRAME_GAP idle cycles, is all solid_color with tuser on its first beat.
6. rst pulsed on beat 13 of a frame.
   - Next cycle tvalid=0, frame_cnt=0, busy=0.
   - Restart with enable begins a fresh frame at x=0, y=0 with tuser=1.

Source files
------------

// File: rtl/axis_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pattern_gen_if
//  Purpose  : AXI4-Stream video bus (data, valid, ready, start-of-frame, end-of-line)
//  Revision : 1.0
// ============================================================================
interface axis_pattern_gen_if #(
    parameter int W = 24
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tuser;
    logic         tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pattern_gen
//  Purpose  : AXI4-Stream video test-pattern source with backpressure and gaps
//  Revision : 1.0
// ============================================================================
module axis_pattern_gen #(
    parameter int DSIZE     = 24,
    parameter int PPC       = 1,
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080,
    parameter int LINE_GAP  = 0,
    parameter int FRAME_GAP = 16,
    parameter int CHK_LOG2  = 4
) (
    input  wire logic             clock,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic [1:0]       mode,
    input  wire logic [DSIZE-1:0] solid_color,
    axis_pattern_gen_if.master    m_axis,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int c_cw     = DSIZE / 3;
    localparam int c_bw     = DSIZE * PPC;
    localparam int c_xw     = $clog2(H_ACTIVE + 1);
    localparam int c_yw     = $clog2(V_ACTIVE + 1);
    localparam int c_fgap_n = (FRAME_GAP < 1) ? 1 : FRAME_GAP;
    localparam int c_gmax   = (LINE_GAP > c_fgap_n) ? LINE_GAP : c_fgap_n;
    localparam int c_gw     = $clog2(c_gmax + 1);

    localparam logic [c_xw-1:0] c_x_last = c_xw'(H_ACTIVE - PPC);
    localparam logic [c_yw-1:0] c_y_last = c_yw'(V_ACTIVE - 1);
    localparam logic [c_gw-1:0] c_lgap_ld = c_gw'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [c_gw-1:0] c_fgap_ld = c_gw'(c_fgap_n - 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_active = 2'd1;
    localparam logic [1:0] c_lgap   = 2'd2;
    localparam logic [1:0] c_fgap   = 2'd3;

    logic [1:0]       r_state_q,     w_state_d;
    logic [c_xw-1:0]  r_x_q,         w_x_d;
    logic [c_yw-1:0]  r_y_q,         w_y_d;
    logic [c_gw-1:0]  r_gap_q,       w_gap_d;
    logic [1:0]       r_mode_q,      w_mode_d;
    logic [DSIZE-1:0] r_solid_q,     w_solid_d;
    logic [c_bw-1:0]  r_tdata_q,     w_tdata_d;
    logic             r_tvalid_q,    w_tvalid_d;
    logic             r_tuser_q,     w_tuser_d;
    logic             r_tlast_q,     w_tlast_d;
    logic [15:0]      r_frame_cnt_q, w_frame_cnt_d;
    logic             w_fire;
    logic             w_load;
    logic             w_first;

    // Bars: bar index is the count of constant boundaries b*H/8 that px*8 has reached.
    function automatic logic [DSIZE-1:0] pixel_at(input int px, input int py,
                                                  input logic [1:0] m,
                                                  input logic [DSIZE-1:0] s);
        logic [2:0] bar;
        logic       on;
        pixel_at = '0;
        bar      = '0;
        on       = 1'b0;
        case (m)
            2'd0: pixel_at = DSIZE'(px);
            2'd1: begin
                for (int b = 1; b < 8; b++) begin
                    if (px * 8 >= b * H_ACTIVE) bar = 3'(b);
                end
                pixel_at = {{c_cw{~bar[1]}}, {c_cw{~bar[2]}}, {c_cw{~bar[0]}}};
            end
            2'd2: begin
                on       = (((px >> CHK_LOG2) ^ (py >> CHK_LOG2)) & 1) != 0;
                pixel_at = {DSIZE{on}};
            end
            default: pixel_at = s;
        endcase
    endfunction

    function automatic logic [c_bw-1:0] beat_at(input int bx, input int by,
                                                input logic [1:0] m,
                                                input logic [DSIZE-1:0] s);
        beat_at = '0;
        for (int k = 0; k < PPC; k++) begin
            beat_at[k*DSIZE +: DSIZE] = pixel_at(bx + k, by, m, s);
        end
    endfunction

    assign w_fire = r_tvalid_q & m_axis.tready;

    always_comb begin
        w_state_d     = r_state_q;
        w_x_d         = r_x_q;
        w_y_d         = r_y_q;
        w_gap_d       = r_gap_q;
        w_mode_d      = r_mode_q;
        w_solid_d     = r_solid_q;
        w_tdata_d     = r_tdata_q;
        w_tvalid_d    = r_tvalid_q;
        w_tuser_d     = r_tuser_q;
        w_tlast_d     = r_tlast_q;
        w_frame_cnt_d = r_frame_cnt_q;
        w_load        = 1'b0;
        w_first       = 1'b0;

        case (r_state_q)
            c_idle: begin
                if (enable) begin
                    w_mode_d  = mode;
                    w_solid_d = solid_color;
                    w_state_d = c_active;
                    w_load    = 1'b1;
                    w_first   = 1'b1;
                end
            end
            c_active: begin
                if (w_fire) begin
                    if (r_x_q == c_x_last) begin
                        w_x_d = '0;
                        if (r_y_q == c_y_last) begin
                            w_y_d         = '0;
                            w_frame_cnt_d = r_frame_cnt_q + 16'd1;
                            w_state_d     = c_fgap;
                            w_tvalid_d    = 1'b0;
                            w_gap_d       = c_fgap_ld;
                        end else begin
                            w_y_d = r_y_q + c_yw'(1);
                            if (LINE_GAP == 0) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_d  = c_lgap;
                                w_tvalid_d = 1'b0;
                                w_gap_d    = c_lgap_ld;
                            end
                        end
                    end else begin
                        w_x_d  = r_x_q + c_xw'(PPC);
                        w_load = 1'b1;
                    end
                end
            end
            c_lgap: begin
                if (r_gap_q == '0) begin
                    w_state_d = c_active;
                    w_load    = 1'b1;
                end else begin
                    w_gap_d = r_gap_q - c_gw'(1);
                end
            end
            c_fgap: begin
                if (r_gap_q == '0) begin
                    if (enable) begin
                        w_mode_d  = mode;
                        w_solid_d = solid_color;
                        w_state_d = c_active;
                        w_load    = 1'b1;
                        w_first   = 1'b1;
                    end else begin
                        w_state_d = c_idle;
                    end
                end else begin
                    w_gap_d = r_gap_q - c_gw'(1);
                end
            end
            default: w_state_d = c_idle;
        endcase

        // Outputs are precomputed for the beat that will be presented next cycle.
        if (w_load) begin
            w_tvalid_d = 1'b1;
            w_tuser_d  = w_first;
            w_tlast_d  = (w_x_d == c_x_last);
            w_tdata_d  = beat_at(int'(w_x_d), int'(w_y_d), w_mode_d, w_solid_d);
        end else if (!w_tvalid_d) begin
            w_tuser_d = 1'b0;
            w_tlast_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state_q     <= c_idle;
            r_x_q         <= '0;
            r_y_q         <= '0;
            r_gap_q       <= '0;
            r_mode_q      <= '0;
            r_solid_q     <= '0;
            r_tdata_q     <= '0;
            r_tvalid_q    <= 1'b0;
            r_tuser_q     <= 1'b0;
            r_tlast_q     <= 1'b0;
            r_frame_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_x_q         <= w_x_d;
            r_y_q         <= w_y_d;
            r_gap_q       <= w_gap_d;
            r_mode_q      <= w_mode_d;
            r_solid_q     <= w_solid_d;
            r_tdata_q     <= w_tdata_d;
            r_tvalid_q    <= w_tvalid_d;
            r_tuser_q     <= w_tuser_d;
            r_tlast_q     <= w_tlast_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    assign m_axis.tdata  = r_tdata_q;
    assign m_axis.tvalid = r_tvalid_q;
    assign m_axis.tuser  = r_tuser_q;
    assign m_axis.tlast  = r_tlast_q;
    assign busy          = (r_state_q != c_idle);
    assign frame_cnt     = r_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pattern_gen
//  Purpose  : Directed self-checking bench for axis_pattern_gen (two configurations)
//  Revision : 1.0
// ============================================================================
module tb_axis_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_a, en_b;
    logic [1:0]  mode_a, mode_b;
    logic [23:0] solid_a, solid_b;
    logic        busy_a, busy_b;
    logic [15:0] fc_a, fc_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axis_pattern_gen_if #(.W(24)) ifa ();
    axis_pattern_gen_if #(.W(96)) ifb ();

    axis_pattern_gen #(
        .DSIZE(24), .PPC(1), .H_ACTIVE(8), .V_ACTIVE(4),
        .LINE_GAP(2), .FRAME_GAP(3), .CHK_LOG2(1)
    ) dut_a (
        .clock(clk), .rst(rst), .enable(en_a), .mode(mode_a), .solid_color(solid_a),
        .m_axis(ifa), .busy(busy_a), .frame_cnt(fc_a)
    );

    axis_pattern_gen #(
        .DSIZE(24), .PPC(4), .H_ACTIVE(16), .V_ACTIVE(2),
        .LINE_GAP(0), .FRAME_GAP(1), .CHK_LOG2(4)
    ) dut_b (
        .clock(clk), .rst(rst), .enable(en_b), .mode(mode_b), .solid_color(solid_b),
        .m_axis(ifb), .busy(busy_b), .frame_cnt(fc_b)
    );

    logic [23:0] bd [64];
    logic        bu [64];
    logic        bl [64];
    int          bc [64];
    int          nrec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        en_a       = 1'b0;
        en_b       = 1'b0;
        ifa.tready = 1'b0;
        ifb.tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Records accepted beats of DUT A; can switch mode / drop enable at given beat counts.
    task automatic collect_a(input int nb, input bit rnd, input int sw_at, input int drop_at);
        logic [15:0] rpat;
        bit          stall;
        logic [23:0] sd;
        logic        su, sl;
        int          guard;
        rpat  = 16'b1011_0010_0110_1001;
        stall = 1'b0;
        sd    = '0;
        su    = 1'b0;
        sl    = 1'b0;
        nrec  = 0;
        guard = 0;
        while (nrec < nb && guard < 600) begin
            tick();
            guard++;
            if (stall) begin
                checks++;
                if (ifa.tvalid !== 1'b1 || ifa.tdata !== sd || ifa.tuser !== su || ifa.tlast !== sl) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h u=%b l=%b, required v=1 d=%h u=%b l=%b",
                             ifa.tvalid, ifa.tdata, ifa.tuser, ifa.tlast, sd, su, sl);
                end
            end
            if (nrec == sw_at) mode_a = 2'd3;
            if (nrec == drop_at) en_a = 1'b0;
            ifa.tready = rnd ? rpat[guard % 16] : 1'b1;
            stall = ifa.tvalid && !ifa.tready;
            sd    = ifa.tdata;
            su    = ifa.tuser;
            sl    = ifa.tlast;
            if (ifa.tvalid && ifa.tready) begin
                bd[nrec] = ifa.tdata;
                bu[nrec] = ifa.tuser;
                bl[nrec] = ifa.tlast;
                bc[nrec] = cyc;
                nrec++;
            end
        end
        if (nrec < nb) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: got %0d beats, required %0d", nrec, nb);
        end
    endtask

    task automatic wait_idle_a();
        int guard;
        guard = 0;
        while (busy_a !== 1'b0 && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy_a);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ifa.tvalid !== 1'b0 || ifa.tuser !== 1'b0 || ifa.tlast !== 1'b0 || ifa.tdata !== 24'h0) begin
            errors++;
            $display("FAIL reset_axis_a: got v=%b u=%b l=%b d=%h, required all 0",
                     ifa.tvalid, ifa.tuser, ifa.tlast, ifa.tdata);
        end
        checks++;
        if (busy_a !== 1'b0 || fc_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_status_a: got busy=%b fc=%0d, required 0 0", busy_a, fc_a);
        end
        checks++;
        if (ifb.tvalid !== 1'b0 || ifb.tdata !== 96'h0 || busy_b !== 1'b0 || fc_b !== 16'd0) begin
            errors++;
            $display("FAIL reset_b: got v=%b d=%h busy=%b fc=%0d, required all 0",
                     ifb.tvalid, ifb.tdata, busy_b, fc_b);
        end
    endtask

    task automatic test_counter_frame();
        int c0;
        apply_reset();
        mode_a = 2'd0;
        en_a   = 1'b1;
        c0     = cyc;
        collect_a(32, 1'b0, -1, 0);
        checks++;
        if (bc[0] !== c0 + 1) begin
            errors++;
            $display("FAIL start_latency: got %0d cycles, required 1", bc[0] - c0);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bd[i] !== 24'(i % 8) || bu[i] !== (i == 0) || bl[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL counter_beat%0d: got d=%h u=%b l=%b, required d=%h u=%b l=%b",
                         i, bd[i], bu[i], bl[i], i % 8, (i == 0), (i % 8 == 7));
            end
        end
        for (int l = 1; l < 4; l++) begin
            checks++;
            if (bc[l*8] - bc[l*8-1] !== 3) begin
                errors++;
                $display("FAIL line_gap%0d: got spacing %0d, required 3", l, bc[l*8] - bc[l*8-1]);
            end
        end
        tick();
        checks++;
        if (fc_a !== 16'd1 || ifa.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: got fc=%0d v=%b, required fc=1 v=0", fc_a, ifa.tvalid);
        end
        tick();
        tick();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL fgap_busy: got busy=%b, required 1", busy_a);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0 || fc_a !== 16'd1) begin
            errors++;
            $display("FAIL idle_after_frame: got busy=%b fc=%0d, required 0 1", busy_a, fc_a);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mode_a = 2'd0;
        en_a   = 1'b1;
        collect_a(32, 1'b1, -1, 0);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bd[i] !== 24'(i % 8) || bu[i] !== (i == 0) || bl[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got d=%h u=%b l=%b, required d=%h u=%b l=%b",
                         i, bd[i], bu[i], bl[i], i % 8, (i == 0), (i % 8 == 7));
            end
        end
        wait_idle_a();
    endtask

    task automatic test_checker();
        logic [7:0] pat;
        apply_reset();
        mode_a = 2'd2;
        en_a   = 1'b1;
        collect_a(32, 1'b0, -1, 0);
        for (int i = 0; i < 32; i++) begin
            pat = (i < 16) ? 8'b1100_1100 : 8'b0011_0011;
            checks++;
            if (bd[i] !== {24{pat[i % 8]}}) begin
                errors++;
                $display("FAIL checker_px%0d: got %h, required %h", i, bd[i], {24{pat[i % 8]}});
            end
        end
        wait_idle_a();
    endtask

    task automatic test_mode_switch();
        apply_reset();
        mode_a  = 2'd0;
        solid_a = 24'hA55A3C;
        en_a    = 1'b1;
        collect_a(64, 1'b0, 10, 40);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bd[i] !== ((i < 32) ? 24'(i % 8) : 24'hA55A3C) || bu[i] !== (i % 32 == 0)) begin
                errors++;
                $display("FAIL switch_beat%0d: got d=%h u=%b, required d=%h u=%b",
                         i, bd[i], bu[i], (i < 32) ? 24'(i % 8) : 24'hA55A3C, (i % 32 == 0));
            end
        end
        checks++;
        if (bc[32] - bc[31] !== 4) begin
            errors++;
            $display("FAIL frame_gap: got spacing %0d, required 4", bc[32] - bc[31]);
        end
        wait_idle_a();
        checks++;
        if (fc_a !== 16'd2 || bl[63] !== 1'b1) begin
            errors++;
            $display("FAIL switch_end: got fc=%0d last=%b, required fc=2 last=1", fc_a, bl[63]);
        end
    endtask

    task automatic test_reset_mid_frame();
        mode_a = 2'd0;
        en_a   = 1'b1;
        collect_a(13, 1'b0, -1, 0);
        tick();
        checks++;
        if (ifa.tvalid !== 1'b1 || ifa.tdata !== 24'd5 || fc_a !== 16'd2) begin
            errors++;
            $display("FAIL beat13: got v=%b d=%h fc=%0d, required v=1 d=000005 fc=2",
                     ifa.tvalid, ifa.tdata, fc_a);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ifa.tvalid !== 1'b0 || ifa.tuser !== 1'b0 || ifa.tlast !== 1'b0 || ifa.tdata !== 24'h0
            || fc_a !== 16'd0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b u=%b l=%b d=%h fc=%0d busy=%b, required all 0",
                     ifa.tvalid, ifa.tuser, ifa.tlast, ifa.tdata, fc_a, busy_a);
        end
        rst  = 1'b0;
        en_a = 1'b1;
        collect_a(8, 1'b0, -1, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bd[i] !== 24'(i) || bu[i] !== (i == 0) || bl[i] !== (i == 7)) begin
                errors++;
                $display("FAIL restart_beat%0d: got d=%h u=%b l=%b, required d=%h u=%b l=%b",
                         i, bd[i], bu[i], bl[i], i, (i == 0), (i == 7));
            end
        end
        apply_reset();
    endtask

    task automatic test_colour_bars();
        logic [95:0] exp_b [4];
        logic [95:0] bdb [8];
        logic        bub [8];
        logic        blb [8];
        int          bcb [8];
        int          n, guard;
        exp_b[0] = 96'hFFFF00_FFFF00_FFFFFF_FFFFFF;
        exp_b[1] = 96'h00FF00_00FF00_00FFFF_00FFFF;
        exp_b[2] = 96'hFF0000_FF0000_FF00FF_FF00FF;
        exp_b[3] = 96'h000000_000000_0000FF_0000FF;
        apply_reset();
        mode_b = 2'd1;
        en_b   = 1'b1;
        n      = 0;
        guard  = 0;
        while (n < 8 && guard < 100) begin
            tick();
            guard++;
            en_b       = 1'b0;
            ifb.tready = 1'b1;
            if (ifb.tvalid) begin
                bdb[n] = ifb.tdata;
                bub[n] = ifb.tuser;
                blb[n] = ifb.tlast;
                bcb[n] = cyc;
                n++;
            end
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL bars_timeout: got %0d beats, required 8", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bdb[i] !== exp_b[i % 4] || bub[i] !== (i == 0) || blb[i] !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL bars_beat%0d: got d=%h u=%b l=%b, required d=%h u=%b l=%b",
                         i, bdb[i], bub[i], blb[i], exp_b[i % 4], (i == 0), (i % 4 == 3));
            end
        end
        checks++;
        if (n == 8 && bcb[4] - bcb[3] !== 1) begin
            errors++;
            $display("FAIL no_line_gap: got spacing %0d, required 1", bcb[4] - bcb[3]);
        end
        tick();
        checks++;
        if (busy_b !== 1'b1 || fc_b !== 16'd1 || ifb.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bars_fgap: got busy=%b fc=%0d v=%b, required 1 1 0", busy_b, fc_b, ifb.tvalid);
        end
        tick();
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL bars_idle: got busy=%b, required 0", busy_b);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en_a       = 1'b0;
        en_b       = 1'b0;
        mode_a     = 2'd0;
        mode_b     = 2'd0;
        solid_a    = 24'h0;
        solid_b    = 24'h123456;
        ifa.tready = 1'b0;
        ifb.tready = 1'b0;
        test_reset();
        test_counter_frame();
        test_backpressure();
        test_checker();
        test_mode_switch();
        test_reset_mid_frame();
        test_colour_bars();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
